// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select encodings and the load-use detection helper.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regIdx_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERROR   = 2'b10
  } hazardState_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_t;

  // A load in EX whose destination feeds a source the ID instruction actually reads.
  function automatic logic loadUseHazard(
    input logic    exMemRead,
    input regIdx_t exDst,
    input regIdx_t idRs,
    input regIdx_t idRt,
    input logic    idUsesRt
  );
    return exMemRead && (exDst != '0) &&
           ((exDst == idRs) || (idUsesRt && (exDst == idRt)));
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Selects the EX operand source for one source register; MEM beats WB and
// register 0 is never forwarded.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] srcReg,
  input  logic [REG_W-1:0] memDst,
  input  logic             memRegWrite,
  input  logic [REG_W-1:0] wbDst,
  input  logic             wbRegWrite,
  output fwdSel_t          fwdSel
);

  always_comb begin
    fwdSel = FWD_REG;
    if (memRegWrite && (memDst != '0) && (memDst == srcReg)) begin
      fwdSel = FWD_MEM;
    end else if (wbRegWrite && (wbDst != '0) && (wbDst == srcReg)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stage enables/flushes for memory stalls,
// redirects and load-use bubbles, operand forwarding, and statistics.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic [REG_W-1:0] mem_dst,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             error
);

  localparam int unsigned WAIT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  hazardState_t      state;
  hazardState_t      nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic              waitInc;
  logic              waitClr;
  logic              stallInc;
  logic              flushInc;
  logic              loadUse;
  fwdSel_t           fwdSelA;
  fwdSel_t           fwdSelB;

  assign loadUse = loadUseHazard(ex_memread, ex_dst, id_rs, id_rt, id_uses_rt);

  forwarding_unit uFwdA (
    .srcReg      (ex_rs),
    .memDst      (mem_dst),
    .memRegWrite (mem_regwrite),
    .wbDst       (wb_dst),
    .wbRegWrite  (wb_regwrite),
    .fwdSel      (fwdSelA)
  );

  forwarding_unit uFwdB (
    .srcReg      (ex_rt),
    .memDst      (mem_dst),
    .memRegWrite (mem_regwrite),
    .wbDst       (wb_dst),
    .wbRegWrite  (wb_regwrite),
    .fwdSel      (fwdSelB)
  );

  // Forwarding stays live in every state; only reset forces the regfile path.
  assign fwd_a = reset ? 2'(FWD_REG) : 2'(fwdSelA);
  assign fwd_b = reset ? 2'(FWD_REG) : 2'(fwdSelB);
  assign error = (state == ERROR) && !reset;

  // Next state and stage controls; reset leaves the run-through defaults.
  always_comb begin
    nextState  = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    waitInc    = 1'b0;
    waitClr    = 1'b0;
    stallInc   = 1'b0;
    flushInc   = 1'b0;

    if (reset) begin
      nextState = RUN;
    end else begin
      case (state)
        RUN, MEMWAIT: begin
          if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            waitInc  = 1'b1;
            stallInc = 1'b1;
            nextState = (waitCnt == WAIT_LAST) ? ERROR : MEMWAIT;
          end else begin
            waitClr   = 1'b1;
            nextState = RUN;
            if (ex_redirect) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              flushInc   = 1'b1;
            end else if (loadUse) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
              stallInc   = 1'b1;
            end
          end
        end
        default: begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          memwb_en  = 1'b0;
          nextState = ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Consecutive busy cycles; never exceeds WAIT_LIMIT since that edge enters ERROR.
  always_ff @(posedge clk) begin
    if (reset || waitClr) begin
      waitCnt <= '0;
    end else if (waitInc) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallInc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flushInc && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller with a short wait limit
// and narrow counters so timeout and saturation are reachable quickly.
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int unsigned CNT_W = 4;

  // Packed view {pc, ifid, idex, exmem, memwb, ifidFlush, idexFlush}
  localparam logic [6:0] CTL_RUN      = 7'b1111100;
  localparam logic [6:0] CTL_LOADUSE  = 7'b0011101;
  localparam logic [6:0] CTL_REDIRECT = 7'b1111111;
  localparam logic [6:0] CTL_FROZEN   = 7'b0000000;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic             id_uses_rt, ex_memread, ex_redirect;
  logic             mem_regwrite, wb_regwrite, mem_busy;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             error;

  int errors = 0;
  int checks = 0;

  hazard_controller #(.WAIT_LIMIT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_dst       (ex_dst),
    .ex_memread   (ex_memread),
    .ex_redirect  (ex_redirect),
    .mem_dst      (mem_dst),
    .wb_dst       (wb_dst),
    .mem_regwrite (mem_regwrite),
    .wb_regwrite  (wb_regwrite),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCtl(input string tag, input logic [6:0] exp);
    check(tag, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}),
          32'(exp));
  endtask

  task automatic clearInputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_dst = '0;
    ex_memread = 1'b0; ex_redirect = 1'b0;
    mem_dst = '0; wb_dst = '0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    mem_busy = 1'b0;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    // Reset holds run-through controls and suppresses forwarding.
    mem_regwrite = 1'b1; mem_dst = 5'd5; ex_rs = 5'd5;
    ex_memread = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
    #2;
    checkCtl("reset_ctl", CTL_RUN);
    check("reset_fwd_a", 32'(fwd_a), 32'(2'b00));
    check("reset_error", 32'(error), 32'd0);
    tick();
    tick();
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_flush", 32'(flush_cnt), 32'd0);
    check("reset_state", 32'(dut.state), 32'(RUN));
    reset = 1'b0;
    clearInputs();
    #1;
    checkCtl("idle_ctl", CTL_RUN);

    // Load-use on rs.
    ex_memread = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
    #1;
    checkCtl("loaduse_rs_ctl", CTL_LOADUSE);
    tick();
    check("loaduse_rs_stall", 32'(stall_cnt), 32'd1);
    // rt only counts when the instruction reads rt.
    id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
    #1;
    checkCtl("rt_unused_ctl", CTL_RUN);
    id_uses_rt = 1'b1;
    #1;
    checkCtl("loaduse_rt_ctl", CTL_LOADUSE);
    tick();
    check("loaduse_rt_stall", 32'(stall_cnt), 32'd2);
    ex_dst = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checkCtl("loaduse_r0_ctl", CTL_RUN);
    ex_memread = 1'b0; ex_dst = 5'd8; id_rs = 5'd8;
    #1;
    checkCtl("not_load_ctl", CTL_RUN);

    // Redirect outranks load-use.
    ex_memread = 1'b1; ex_redirect = 1'b1;
    #1;
    checkCtl("redirect_ctl", CTL_REDIRECT);
    tick();
    check("redirect_flush", 32'(flush_cnt), 32'd1);
    check("redirect_stall", 32'(stall_cnt), 32'd2);
    clearInputs();

    // Forwarding priority and register 0.
    mem_regwrite = 1'b1; mem_dst = 5'd5; wb_regwrite = 1'b1; wb_dst = 5'd5; ex_rs = 5'd5;
    #1;
    check("fwd_a_mem", 32'(fwd_a), 32'(2'b10));
    mem_dst = 5'd0;
    #1;
    check("fwd_a_wb", 32'(fwd_a), 32'(2'b01));
    wb_dst = 5'd0;
    #1;
    check("fwd_a_reg", 32'(fwd_a), 32'(2'b00));
    mem_regwrite = 1'b0; mem_dst = 5'd7; wb_dst = 5'd7; ex_rt = 5'd7;
    #1;
    check("fwd_b_wb", 32'(fwd_b), 32'(2'b01));
    check("fwd_a_nomatch", 32'(fwd_a), 32'(2'b00));
    clearInputs();

    // Three busy cycles; redirect during busy is ignored.
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_redirect = (i == 1);
      #1;
      checkCtl("busy_ctl", CTL_FROZEN);
      tick();
      check("busy_state", 32'(dut.state), 32'(MEMWAIT));
    end
    check("busy_stall", 32'(stall_cnt), 32'd5);
    check("busy_flush", 32'(flush_cnt), 32'd1);
    mem_busy = 1'b0; ex_redirect = 1'b0;
    #1;
    checkCtl("busy_release_ctl", CTL_RUN);
    tick();
    check("busy_release_state", 32'(dut.state), 32'(RUN));

    // Timeout after the fourth consecutive busy cycle.
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkCtl("timeout_busy_ctl", CTL_FROZEN);
      tick();
      check("timeout_state", 32'(dut.state), (i < 3) ? 32'(MEMWAIT) : 32'(ERROR));
    end
    check("timeout_stall", 32'(stall_cnt), 32'd9);
    mem_busy = 1'b0; ex_redirect = 1'b1;
    mem_regwrite = 1'b1; mem_dst = 5'd4; ex_rs = 5'd4;
    #1;
    checkCtl("error_ctl", CTL_FROZEN);
    check("error_flag", 32'(error), 32'd1);
    check("error_fwd_a", 32'(fwd_a), 32'(2'b10));
    tick();
    check("error_sticky_state", 32'(dut.state), 32'(ERROR));
    check("error_stall_hold", 32'(stall_cnt), 32'd9);
    check("error_flush_hold", 32'(flush_cnt), 32'd1);
    reset = 1'b1;
    #1;
    checkCtl("error_reset_ctl", CTL_RUN);
    check("error_reset_flag", 32'(error), 32'd0);
    check("error_reset_fwd", 32'(fwd_a), 32'(2'b00));
    tick();
    reset = 1'b0;
    clearInputs();
    #1;
    check("recover_state", 32'(dut.state), 32'(RUN));
    check("recover_error", 32'(error), 32'd0);
    check("recover_stall", 32'(stall_cnt), 32'd0);
    check("recover_flush", 32'(flush_cnt), 32'd0);

    // No leftover wait count: three busy cycles stay short of the limit.
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("residual_state", 32'(dut.state), 32'(MEMWAIT));
    mem_busy = 1'b0;
    tick();
    check("residual_release", 32'(dut.state), 32'(RUN));
    check("residual_stall", 32'(stall_cnt), 32'd3);

    // Saturation of both counters.
    ex_redirect = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) check("flush_at_15", 32'(flush_cnt), 32'd15);
    end
    check("flush_saturated", 32'(flush_cnt), 32'd15);
    ex_redirect = 1'b0;
    ex_memread = 1'b1; ex_dst = 5'd8; id_rs = 5'd8;
    for (int i = 0; i < 20; i++) tick();
    check("stall_saturated", 32'(stall_cnt), 32'd15);
    clearInputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
